// File: rtl/usb_buffer_ctrl.sv
// usb_buffer_ctrl: sequencer/arbiter for the shared 64-byte USB data buffer.
// The buffer is granted to one direction at a time. It is either filled by the
// host and drained by the TX encoder, or filled by the RX decoder and drained
// by the host. Store/get strobes are Mealy outputs of the current request.
// Requests that would overflow or underflow the buffer are refused and
// latched into sticky error flags.
module usb_buffer_ctrl #(
    parameter int CAPACITY = 64,
    parameter int OCC_W    = 7
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             host_tx_wr,
    input  logic             host_rx_rd,
    input  logic             host_flush,
    input  logic             err_clr,
    input  logic             tx_start,
    input  logic             tx_get_req,
    input  logic             rx_pkt_start,
    input  logic             rx_store_req,
    input  logic             rx_pkt_done,
    input  logic             rx_pkt_err,
    input  logic [OCC_W-1:0] Buffer_Occupancy,
    output logic             Store_TX_Data,
    output logic             Store_RX_Packet_Data,
    output logic             Get_TX_Packet_Data,
    output logic             Get_RX_Data,
    output logic             flush,
    output logic             clear,
    output logic             tx_ready,
    output logic             rx_data_avail,
    output logic             busy,
    output logic             overflow_err,
    output logic             underflow_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TX_FILL = 3'd1,
        TX_SEND = 3'd2,
        RX_FILL = 3'd3,
        RX_HOLD = 3'd4
    } state_t;

    localparam logic [OCC_W-1:0] CAP_OCC = OCC_W'(CAPACITY);
    localparam logic [OCC_W-1:0] ONE_OCC = OCC_W'(1);

    state_t state_reg;
    state_t state_next;
    logic   overflow_reg;
    logic   underflow_reg;

    // Decoded combinational results for the current cycle
    logic   store_tx;
    logic   store_rx;
    logic   get_tx;
    logic   get_rx;
    logic   flush_pulse;
    logic   clear_pulse;
    logic   overflow_set;
    logic   underflow_set;

    // Occupancy qualifiers. ">=" keeps the controller safe even if the buffer
    // ever reports more than its nominal capacity.
    logic   is_full;
    logic   is_empty;
    logic   is_last;

    assign is_full  = (Buffer_Occupancy >= CAP_OCC);
    assign is_empty = (Buffer_Occupancy == '0);
    assign is_last  = (Buffer_Occupancy == ONE_OCC);

    // State register; asynchronous reset returns to IDLE without a flush pulse
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Sticky error flags: a new refusal takes priority over a simultaneous clear
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (overflow_set) begin
                overflow_reg <= 1'b1;
            end else if (err_clr) begin
                overflow_reg <= 1'b0;
            end
            if (underflow_set) begin
                underflow_reg <= 1'b1;
            end else if (err_clr) begin
                underflow_reg <= 1'b0;
            end
        end
    end

    // Next-state and Mealy strobe decode; host_flush overrides every state
    always_comb begin
        state_next    = state_reg;
        store_tx      = 1'b0;
        store_rx      = 1'b0;
        get_tx        = 1'b0;
        get_rx        = 1'b0;
        flush_pulse   = 1'b0;
        clear_pulse   = 1'b0;
        overflow_set  = 1'b0;
        underflow_set = 1'b0;

        if (host_flush) begin
            flush_pulse = 1'b1;
            state_next  = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Bus traffic cannot be stalled, so an incoming RX packet
                    // wins the buffer over a host write in the same cycle.
                    if (rx_pkt_start) begin
                        state_next = RX_FILL;
                    end else if (host_tx_wr) begin
                        if (is_full) begin
                            overflow_set = 1'b1;
                        end else begin
                            store_tx = 1'b1;
                        end
                        state_next = TX_FILL;
                    end
                end

                TX_FILL: begin
                    // A host byte offered alongside tx_start is still stored;
                    // tx_start needs at least one byte already in the buffer.
                    if (host_tx_wr) begin
                        if (is_full) begin
                            overflow_set = 1'b1;
                        end else begin
                            store_tx = 1'b1;
                        end
                    end
                    if (tx_start && !is_empty) begin
                        state_next = TX_SEND;
                    end
                end

                TX_SEND: begin
                    if (tx_get_req) begin
                        if (is_empty) begin
                            underflow_set = 1'b1;
                        end else begin
                            get_tx = 1'b1;
                            if (is_last) begin
                                state_next = IDLE;
                            end
                        end
                    end
                end

                RX_FILL: begin
                    if (rx_pkt_err) begin
                        // Bad packet: discard everything, byte of this cycle included
                        flush_pulse = 1'b1;
                        clear_pulse = 1'b1;
                        state_next  = IDLE;
                    end else begin
                        if (rx_store_req) begin
                            if (is_full) begin
                                overflow_set = 1'b1;
                            end else begin
                                store_rx = 1'b1;
                            end
                        end
                        if (rx_pkt_done) begin
                            // A zero-length packet leaves nothing for the host
                            if (!is_empty || store_rx) begin
                                state_next = RX_HOLD;
                            end else begin
                                state_next = IDLE;
                            end
                        end
                    end
                end

                RX_HOLD: begin
                    // New RX packets are ignored until the host has drained this one
                    if (host_rx_rd) begin
                        if (is_empty) begin
                            underflow_set = 1'b1;
                        end else begin
                            get_rx = 1'b1;
                            if (is_last) begin
                                state_next = IDLE;
                            end
                        end
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign Store_TX_Data        = store_tx;
    assign Store_RX_Packet_Data = store_rx;
    assign Get_TX_Packet_Data   = get_tx;
    assign Get_RX_Data          = get_rx;
    assign flush                = flush_pulse;
    assign clear                = clear_pulse;
    assign tx_ready             = (state_reg == TX_FILL) && !is_empty;
    assign rx_data_avail        = (state_reg == RX_HOLD) && !is_empty;
    assign busy                 = (state_reg != IDLE);
    assign overflow_err         = overflow_reg;
    assign underflow_err        = underflow_reg;

endmodule

// File: tb/tb_usb_buffer_ctrl.sv
// Directed testbench for usb_buffer_ctrl. The bench plays the role of the
// buffer: it owns the occupancy count and advances it from its own expected
// grants. Each cycle pushes an expected output vector into a scoreboard queue.
// The vector is popped and compared on the falling edge.
module tb_usb_buffer_ctrl;

    logic       clk;
    logic       n_rst;
    logic       host_tx_wr, host_rx_rd, host_flush, err_clr;
    logic       tx_start, tx_get_req;
    logic       rx_pkt_start, rx_store_req, rx_pkt_done, rx_pkt_err;
    logic [6:0] Buffer_Occupancy;
    logic       Store_TX_Data, Store_RX_Packet_Data, Get_TX_Packet_Data, Get_RX_Data;
    logic       flush, clear, tx_ready, rx_data_avail, busy;
    logic       overflow_err, underflow_err;

    // Input stimulus bits
    localparam logic [9:0] I_TXWR  = 10'h200;
    localparam logic [9:0] I_RXRD  = 10'h100;
    localparam logic [9:0] I_FLUSH = 10'h080;
    localparam logic [9:0] I_ECLR  = 10'h040;
    localparam logic [9:0] I_TXS   = 10'h020;
    localparam logic [9:0] I_GET   = 10'h010;
    localparam logic [9:0] I_RXS   = 10'h008;
    localparam logic [9:0] I_RXST  = 10'h004;
    localparam logic [9:0] I_DONE  = 10'h002;
    localparam logic [9:0] I_ERR   = 10'h001;
    localparam logic [9:0] I_NONE  = 10'h000;

    // Expected output bits
    localparam logic [10:0] E_STX  = 11'h400;
    localparam logic [10:0] E_SRX  = 11'h200;
    localparam logic [10:0] E_GTX  = 11'h100;
    localparam logic [10:0] E_GRX  = 11'h080;
    localparam logic [10:0] E_FL   = 11'h040;
    localparam logic [10:0] E_CLR  = 11'h020;
    localparam logic [10:0] E_TXR  = 11'h010;
    localparam logic [10:0] E_RXA  = 11'h008;
    localparam logic [10:0] E_BSY  = 11'h004;
    localparam logic [10:0] E_OVF  = 11'h002;
    localparam logic [10:0] E_UDF  = 11'h001;
    localparam logic [10:0] E_NONE = 11'h000;

    int          errors = 0;
    int          checks = 0;
    int          occ    = 0;
    logic [10:0] exp_q[$];
    string       tag_q[$];

    usb_buffer_ctrl #(.CAPACITY(64), .OCC_W(7)) dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .host_tx_wr           (host_tx_wr),
        .host_rx_rd           (host_rx_rd),
        .host_flush           (host_flush),
        .err_clr              (err_clr),
        .tx_start             (tx_start),
        .tx_get_req           (tx_get_req),
        .rx_pkt_start         (rx_pkt_start),
        .rx_store_req         (rx_store_req),
        .rx_pkt_done          (rx_pkt_done),
        .rx_pkt_err           (rx_pkt_err),
        .Buffer_Occupancy     (Buffer_Occupancy),
        .Store_TX_Data        (Store_TX_Data),
        .Store_RX_Packet_Data (Store_RX_Packet_Data),
        .Get_TX_Packet_Data   (Get_TX_Packet_Data),
        .Get_RX_Data          (Get_RX_Data),
        .flush                (flush),
        .clear                (clear),
        .tx_ready             (tx_ready),
        .rx_data_avail        (rx_data_avail),
        .busy                 (busy),
        .overflow_err         (overflow_err),
        .underflow_err        (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // One clock cycle: drive inputs, queue expectation, compare at negedge,
    // then advance the bench's buffer occupancy after the rising edge.
    task automatic cyc(input string tag, input logic [9:0] ins, input logic [10:0] exp);
        logic [10:0] obs;
        logic [10:0] e;
        string       t;
        {host_tx_wr, host_rx_rd, host_flush, err_clr, tx_start, tx_get_req,
         rx_pkt_start, rx_store_req, rx_pkt_done, rx_pkt_err} = ins;
        Buffer_Occupancy = 7'(occ);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        obs = {Store_TX_Data, Store_RX_Packet_Data, Get_TX_Packet_Data, Get_RX_Data,
               flush, clear, tx_ready, rx_data_avail, busy, overflow_err, underflow_err};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b (stx srx gtx grx fl clr txr rxa bsy ovf udf) occ=%0d",
                   t, obs, e, occ);
        end
        $display("cycle %-16s occ=%0d exp=%b obs=%b", t, occ, e, obs);
        @(posedge clk);
        if ((e & (E_FL | E_CLR)) != 0) begin
            occ = 0;
        end else begin
            occ = occ + ((e & E_STX) != 0 ? 1 : 0) + ((e & E_SRX) != 0 ? 1 : 0)
                      - ((e & E_GTX) != 0 ? 1 : 0) - ((e & E_GRX) != 0 ? 1 : 0);
        end
        #1;
    endtask

    initial begin
        n_rst = 1'b0;
        {host_tx_wr, host_rx_rd, host_flush, err_clr, tx_start, tx_get_req,
         rx_pkt_start, rx_store_req, rx_pkt_done, rx_pkt_err} = I_NONE;
        Buffer_Occupancy = '0;
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", I_NONE, E_NONE);
        n_rst = 1'b1;

        // T1: three host bytes, start, three gets back to IDLE
        cyc("t1_wr0", I_TXWR, E_STX);
        cyc("t1_wr1", I_TXWR, E_STX | E_TXR | E_BSY);
        cyc("t1_wr2", I_TXWR, E_STX | E_TXR | E_BSY);
        cyc("t1_start", I_TXS, E_TXR | E_BSY);
        for (int i = 0; i < 3; i++) cyc("t1_get", I_GET, E_GTX | E_BSY);
        cyc("t1_idle", I_NONE, E_NONE);

        // T3: RX start beats host write in IDLE
        cyc("t3_rx_vs_tx", I_RXS | I_TXWR, E_NONE);
        // T2: fill to capacity, one refused store, done, drain
        for (int i = 0; i < 64; i++) cyc("t2_store", I_RXST, E_SRX | E_BSY);
        cyc("t2_store_full", I_RXST, E_BSY);
        cyc("t2_done", I_DONE, E_BSY | E_OVF);
        for (int i = 0; i < 64; i++)
            cyc("t2_read", I_RXRD | ((i == 0) ? I_RXS : I_NONE), E_GRX | E_RXA | E_BSY | E_OVF);
        cyc("t2_clr", I_ECLR, E_OVF);
        cyc("t2_idle", I_NONE, E_NONE);

        // T4: RX error with five bytes buffered
        cyc("t4_start", I_RXS, E_NONE);
        for (int i = 0; i < 5; i++) cyc("t4_store", I_RXST, E_SRX | E_BSY);
        cyc("t4_err", I_ERR | I_RXST, E_FL | E_CLR | E_BSY);
        cyc("t4_idle", I_NONE, E_NONE);

        // Zero-length packet returns to IDLE; store in the done cycle holds
        cyc("rx0_start", I_RXS, E_NONE);
        cyc("rx0_done", I_DONE, E_BSY);
        cyc("rx0_idle", I_NONE, E_NONE);
        cyc("rx1_start", I_RXS, E_NONE);
        cyc("rx1_store_done", I_RXST | I_DONE, E_SRX | E_BSY);
        cyc("rx1_hold", I_NONE, E_RXA | E_BSY);
        cyc("rx1_read", I_RXRD, E_GRX | E_RXA | E_BSY);
        cyc("rx1_idle", I_NONE, E_NONE);

        // TX overflow at capacity, flush out of TX_SEND
        cyc("txo_wr", I_TXWR, E_STX);
        occ = 64;
        cyc("txo_full", I_TXWR | I_TXS, E_TXR | E_BSY);
        cyc("txo_flag", I_NONE, E_BSY | E_OVF);
        cyc("txo_flush", I_FLUSH | I_GET, E_FL | E_BSY | E_OVF);
        cyc("txo_clr", I_ECLR, E_OVF);
        cyc("txo_idle", I_NONE, E_NONE);

        // tx_start ignored while buffer is empty
        cyc("txz_wr", I_TXWR, E_STX);
        occ = 0;
        cyc("txz_start_empty", I_TXS, E_BSY);
        cyc("txz_wr_start", I_TXWR | I_TXS, E_STX | E_BSY);
        cyc("txz_start_ok", I_TXS, E_TXR | E_BSY);

        // T5: get refused in TX_SEND at occupancy 0, clear, set beats clear
        occ = 0;
        cyc("t5_get_empty", I_GET, E_BSY);
        cyc("t5_flag", I_NONE, E_BSY | E_UDF);
        cyc("t5_clr", I_ECLR, E_BSY | E_UDF);
        cyc("t5_cleared", I_NONE, E_BSY);
        cyc("t5_set_wins", I_GET | I_ECLR, E_BSY);
        cyc("t5_flag2", I_NONE, E_BSY | E_UDF);

        // T6: flush in TX_SEND with ten bytes
        occ = 10;
        cyc("t6_flush", I_FLUSH | I_GET, E_FL | E_BSY | E_UDF);
        cyc("t6_idle", I_ECLR, E_UDF);
        cyc("t6_cleared", I_NONE, E_NONE);

        // Reset mid-packet: immediate IDLE, no flush pulse
        cyc("rst_start", I_RXS, E_NONE);
        cyc("rst_store", I_RXST, E_SRX | E_BSY);
        n_rst = 1'b0;
        occ = 0;
        cyc("rst_mid", I_RXST, E_NONE);
        n_rst = 1'b1;
        cyc("rst_after", I_NONE, E_NONE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
